// File: rtl/mm_read_arbiter.sv
// mm_read_arbiter: shares the main-memory read port among the test port,
// VGA scanout and CPU. Fixed priority test > VGA > CPU. A VGA streak limit
// keeps the CPU from starving. Reads that collide with the registered write
// are held off for one cycle. Returned data is tagged back to its requester
// through an RD_LAT-deep tag pipeline. The CPU write path is registered.
module mm_read_arbiter #(
  parameter int ADDR_W  = 19,  // RAM address width (must be < 32)
  parameter int RD_LAT  = 2,   // grant cycle to data cycle, must be >= 1
  parameter int VGA_MAX = 4    // max consecutive VGA grants while CPU waits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              test_rreq,
  input  logic [31:0]       test_raddr,
  output logic              test_rgnt,
  output logic              test_rvalid,
  input  logic              vga_rreq,
  input  logic [31:0]       vga_raddr,
  output logic              vga_rgnt,
  output logic              vga_rvalid,
  input  logic              cpu_rreq,
  input  logic [31:0]       cpu_raddr,
  output logic              cpu_rgnt,
  output logic              cpu_rvalid,
  input  logic              cpu_wren,
  input  logic [31:0]       cpu_waddr,
  input  logic [7:0]        cpu_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wren,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        rdata
);

  localparam int STREAK_W = $clog2(VGA_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VGA_MAX);

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_TEST = 2'd1,
    ID_VGA  = 2'd2,
    ID_CPU  = 2'd3
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  logic [ADDR_W-1:0]   r_mem_raddr;
  logic [ADDR_W-1:0]   r_mem_waddr;
  logic [7:0]          r_mem_wdata;
  logic                r_mem_wren;
  logic [STREAK_W-1:0] r_vga_streak;
  tag_t                r_tag [RD_LAT];

  logic [ADDR_W-1:0] w_test_addr, w_vga_addr, w_cpu_addr;
  logic              w_test_ok, w_vga_ok, w_cpu_ok;
  logic              w_test_win, w_vga_win, w_cpu_win;
  logic              w_test_gnt, w_vga_gnt, w_cpu_gnt;
  req_id_t           w_win_id;
  logic [ADDR_W-1:0] w_win_addr;
  tag_t              w_out_tag;

  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{test_raddr[31:ADDR_W], vga_raddr[31:ADDR_W],
                                cpu_raddr[31:ADDR_W], cpu_waddr[31:ADDR_W]};

  assign w_test_addr = test_raddr[ADDR_W-1:0];
  assign w_vga_addr  = vga_raddr[ADDR_W-1:0];
  assign w_cpu_addr  = cpu_raddr[ADDR_W-1:0];

  // A read of the location being written this cycle would return stale
  // data, so that requester sits out one cycle.
  assign w_test_ok = test_rreq && !(r_mem_wren && (w_test_addr == r_mem_waddr));
  assign w_vga_ok  = vga_rreq  && !(r_mem_wren && (w_vga_addr  == r_mem_waddr));
  assign w_cpu_ok  = cpu_rreq  && !(r_mem_wren && (w_cpu_addr  == r_mem_waddr));

  // Priority among eligible requesters. The CPU overtakes VGA once the streak
  // limit is reached, or when VGA is not eligible this cycle.
  assign w_test_win = w_test_ok;
  assign w_cpu_win  = !w_test_ok && w_cpu_ok && ((r_vga_streak == STREAK_MAX) || !w_vga_ok);
  assign w_vga_win  = !w_test_ok && !w_cpu_win && w_vga_ok;

  // Grants are suppressed while reset is asserted.
  assign w_test_gnt = rst_n && w_test_win;
  assign w_vga_gnt  = rst_n && w_vga_win;
  assign w_cpu_gnt  = rst_n && w_cpu_win;

  assign test_rgnt = w_test_gnt;
  assign vga_rgnt  = w_vga_gnt;
  assign cpu_rgnt  = w_cpu_gnt;

  // Select the winning id and address for the read port.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_win_id   = ID_NONE;
    w_win_addr = r_mem_raddr;
    if (w_test_gnt) begin
      w_win_id   = ID_TEST;
      w_win_addr = w_test_addr;
    end else if (w_cpu_gnt) begin
      w_win_id   = ID_CPU;
      w_win_addr = w_cpu_addr;
    end else if (w_vga_gnt) begin
      w_win_id   = ID_VGA;
      w_win_addr = w_vga_addr;
    end
  end

  // Register the read address on a grant. Otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_raddr <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
      r_mem_raddr <= w_win_addr;
    end
  end

  // Register the CPU write path every cycle, independent of arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wren  <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_wren  <= cpu_wren;
      r_mem_waddr <= cpu_waddr[ADDR_W-1:0];
      r_mem_wdata <= cpu_wdata;
    end
  end

  // Count consecutive VGA wins while the CPU is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga_streak <= '0;
    end else if (!cpu_rreq || w_cpu_gnt) begin
      r_vga_streak <= '0;
    end else if (w_vga_gnt && (r_vga_streak != STREAK_MAX)) begin
      r_vga_streak <= r_vga_streak + 1'b1;
    end
  end

  // Tag pipeline: the tag pushed at a grant surfaces RD_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: unlike a data RAM, this array must be reset, or a stale valid would fire a spurious rvalid.
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag[i] <= '{valid: 1'b0, id: ID_NONE};
      end
    end else begin
      r_tag[0] <= '{valid: (w_win_id != ID_NONE), id: w_win_id};
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_out_tag   = r_tag[RD_LAT-1];
  assign test_rvalid = w_out_tag.valid && (w_out_tag.id == ID_TEST);
  assign vga_rvalid  = w_out_tag.valid && (w_out_tag.id == ID_VGA);
  assign cpu_rvalid  = w_out_tag.valid && (w_out_tag.id == ID_CPU);

  assign mem_raddr = r_mem_raddr;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wren  = r_mem_wren;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mm_read_arbiter.sv
// Directed bench for mm_read_arbiter. A behavioural RAM has a one-cycle
// synchronous read, so data arrives RD_LAT = 2 cycles after a grant.
module tb_mm_read_arbiter;

  localparam int ADDR_W  = 19;
  localparam int RD_LAT  = 2;
  localparam int VGA_MAX = 4;

  logic              clk, rst_n;
  logic              test_rreq, vga_rreq, cpu_rreq, cpu_wren;
  logic [31:0]       test_raddr, vga_raddr, cpu_raddr, cpu_waddr;
  logic [7:0]        cpu_wdata, mem_rdata, mem_wdata, rdata;
  logic              test_rgnt, vga_rgnt, cpu_rgnt;
  logic              test_rvalid, vga_rvalid, cpu_rvalid, mem_wren;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;

  mm_read_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .VGA_MAX(VGA_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .test_rreq(test_rreq), .test_raddr(test_raddr), .test_rgnt(test_rgnt), .test_rvalid(test_rvalid),
    .vga_rreq(vga_rreq), .vga_raddr(vga_raddr), .vga_rgnt(vga_rgnt), .vga_rvalid(vga_rvalid),
    .cpu_rreq(cpu_rreq), .cpu_raddr(cpu_raddr), .cpu_rgnt(cpu_rgnt), .cpu_rvalid(cpu_rvalid),
    .cpu_wren(cpu_wren), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: the write lands on the edge, and the read is registered once.
  logic [7:0] ram [0:(1<<ADDR_W)-1];
  logic [7:0] ram_q;
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_waddr] <= mem_wdata;
    ram_q <= ram[mem_raddr];
  end

  // Preload pattern, so each address returns a distinguishable byte.
  function automatic logic [7:0] rf(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  typedef struct {
    bit          tr;  logic [31:0] ta;
    bit          vr;  logic [31:0] va;
    bit          cr;  logic [31:0] ca;
    bit          we;  logic [31:0] wa;  logic [7:0] wd;
    logic [2:0]  gnt;   // {test, vga, cpu}
    logic [2:0]  rv;    // {test, vga, cpu}
    bit          crd;
    logic [7:0]  rd;
  } vec_t;

  function automatic vec_t mk(bit tr, logic [31:0] ta, bit vr, logic [31:0] va,
                              bit cr, logic [31:0] ca, bit we, logic [31:0] wa,
                              logic [7:0] wd, logic [2:0] gnt, logic [2:0] rv,
                              bit crd, logic [7:0] rd);
    vec_t v;
    v.tr = tr; v.ta = ta; v.vr = vr; v.va = va; v.cr = cr; v.ca = ca;
    v.we = we; v.wa = wa; v.wd = wd; v.gnt = gnt; v.rv = rv; v.crd = crd; v.rd = rd;
    return v;
  endfunction

  int pass_cnt  = 0;
  int total_cnt = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    test_rreq = v.tr; test_raddr = v.ta;
    vga_rreq  = v.vr; vga_raddr  = v.va;
    cpu_rreq  = v.cr; cpu_raddr  = v.ca;
    cpu_wren  = v.we; cpu_waddr  = v.wa; cpu_wdata = v.wd;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Inputs change just after the rising edge. Outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = rf(ADDR_W'(i));
    rst_n = 1'b0;
    idle_inputs();

    // ---- Priority: all three at once, then VGA, then CPU ----
    vecs.push_back(mk(1,'h20, 1,'h30, 1,'h40, 0,0,0, 3'b100, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0,    1,'h30, 1,'h40, 0,0,0, 3'b010, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0,    0,0,    1,'h40, 0,0,0, 3'b001, 3'b100, 1, rf('h20)));
    vecs.push_back(mk(0,0,    0,0,    0,0,    0,0,0, 3'b000, 3'b010, 1, rf('h30)));
    vecs.push_back(mk(0,0,    0,0,    0,0,    0,0,0, 3'b000, 3'b001, 1, rf('h40)));
    vecs.push_back(mk(0,0,    0,0,    0,0,    0,0,0, 3'b000, 3'b000, 0, 8'h00));
    // ---- Starvation: V,V,V,V,C,V,V,V,V,C ----
    vecs.push_back(mk(0,0, 1,'h200, 1,'h300, 0,0,0, 3'b010, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 1,'h201, 1,'h300, 0,0,0, 3'b010, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 1,'h202, 1,'h300, 0,0,0, 3'b010, 3'b010, 1, rf('h200)));
    vecs.push_back(mk(0,0, 1,'h203, 1,'h300, 0,0,0, 3'b010, 3'b010, 1, rf('h201)));
    vecs.push_back(mk(0,0, 1,'h204, 1,'h300, 0,0,0, 3'b001, 3'b010, 1, rf('h202)));
    vecs.push_back(mk(0,0, 1,'h204, 1,'h301, 0,0,0, 3'b010, 3'b010, 1, rf('h203)));
    vecs.push_back(mk(0,0, 1,'h205, 1,'h301, 0,0,0, 3'b010, 3'b001, 1, rf('h300)));
    vecs.push_back(mk(0,0, 1,'h206, 1,'h301, 0,0,0, 3'b010, 3'b010, 1, rf('h204)));
    vecs.push_back(mk(0,0, 1,'h207, 1,'h301, 0,0,0, 3'b010, 3'b010, 1, rf('h205)));
    vecs.push_back(mk(0,0, 1,'h208, 1,'h301, 0,0,0, 3'b001, 3'b010, 1, rf('h206)));
    vecs.push_back(mk(0,0, 1,'h208, 0,0,     0,0,0, 3'b010, 3'b010, 1, rf('h207)));
    vecs.push_back(mk(0,0, 0,0,     0,0,     0,0,0, 3'b000, 3'b001, 1, rf('h301)));
    vecs.push_back(mk(0,0, 0,0,     0,0,     0,0,0, 3'b000, 3'b010, 1, rf('h208)));
    // ---- Back-to-back VGA stream 0x100..0x107, plus drain ----
    for (int k = 0; k < 11; k++) begin
      vecs.push_back(mk(0,0, (k < 8), (k < 8) ? 32'h100 + k : 32'h0, 0,0, 0,0,0,
                        (k < 8) ? 3'b010 : 3'b000,
                        (k >= 2 && k < 10) ? 3'b010 : 3'b000,
                        (k >= 2 && k < 10), rf(ADDR_W'(32'h100 + k - 2))));
    end
    // ---- Write hazard: CPU held off, then next-eligible skips blocked VGA ----
    vecs.push_back(mk(0,0, 0,0,     0,0,     1,'h55,8'hA5, 3'b000, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 0,0,     1,'h55,  0,0,0,        3'b000, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 0,0,     1,'h55,  0,0,0,        3'b001, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 0,0,     0,0,     1,'h77,8'h5B, 3'b000, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 1,'h77,  1,'h78,  0,0,0,        3'b001, 3'b001, 1, 8'hA5));
    vecs.push_back(mk(0,0, 1,'h77,  0,0,     0,0,0,        3'b010, 3'b000, 0, 8'h00));
    vecs.push_back(mk(0,0, 0,0,     0,0,     0,0,0,        3'b000, 3'b001, 1, rf('h78)));
    vecs.push_back(mk(0,0, 0,0,     0,0,     0,0,0,        3'b000, 3'b010, 1, 8'h5B));

    // ---- Reset state ----
    next_cycle();
    @(negedge clk);
    check("reset_gnt",    {test_rgnt, vga_rgnt, cpu_rgnt}, 0);
    check("reset_rvalid", {test_rvalid, vga_rvalid, cpu_rvalid}, 0);
    check("reset_mem",    {mem_wren, mem_wdata, mem_raddr}, 0);
    check("reset_waddr",  mem_waddr, 0);
    next_cycle();
    rst_n = 1'b1;

    // ---- Table ----
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), {test_rgnt, vga_rgnt, cpu_rgnt}, vecs[i].gnt);
      check($sformatf("v%0d_rvalid", i), {test_rvalid, vga_rvalid, cpu_rvalid}, vecs[i].rv);
      if (vecs[i].crd) check($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
      next_cycle();
    end

    // ---- Alias: upper address bits are dropped; raddr holds when idle ----
    idle_inputs();
    cpu_rreq = 1'b1; cpu_raddr = 32'h0008_0003;
    @(negedge clk);
    check("alias_gnt",  {test_rgnt, vga_rgnt, cpu_rgnt}, 3'b001);
    check("raddr_hold", mem_raddr, 19'h00077);
    next_cycle();
    cpu_rreq = 1'b0;
    @(negedge clk);
    check("alias_raddr", mem_raddr, 19'h00003);
    next_cycle();
    @(negedge clk);
    check("alias_rvalid", {test_rvalid, vga_rvalid, cpu_rvalid}, 3'b001);
    check("alias_rdata",  rdata, rf(19'h00003));
    next_cycle();

    // ---- Reset mid-read: the in-flight CPU read must vanish ----
    idle_inputs();
    cpu_rreq = 1'b1; cpu_raddr = 32'h10;
    cpu_wren = 1'b1; cpu_waddr = 32'h1234; cpu_wdata = 8'h99;
    @(negedge clk);
    check("rst_mid_gnt", cpu_rgnt, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    vga_rreq = 1'b1; vga_raddr = 32'h40;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_gnt0_%0d", c), {test_rgnt, vga_rgnt, cpu_rgnt}, 0);
      check($sformatf("rst_mid_rv0_%0d", c), {test_rvalid, vga_rvalid, cpu_rvalid}, 0);
      check($sformatf("rst_mid_mem0_%0d", c), {mem_wren, mem_wdata, mem_raddr}, 0);
      check($sformatf("rst_mid_waddr0_%0d", c), mem_waddr, 0);
      next_cycle();
    end
    idle_inputs();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_rv_%0d", c), {test_rvalid, vga_rvalid, cpu_rvalid}, 0);
      next_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mm_read_arbiter.md
Name: mm_read_arbiter

Overview:
- Shares the single main-memory read port (8-bit data, 19-bit address) among three requesters (test port, VGA scanout, CPU) with per-requester req/gnt/rvalid handshakes; replaces the static select-mux in front of the RAM.
- Also registers the CPU write path, and tracks in-flight reads so returned data is tagged to its requester.
- Fixed priority test > VGA > CPU, with a VGA streak limit so the CPU is never starved.

Parameters:
- ADDR_W, 19, RAM address width; requester addresses are truncated to [ADDR_W-1:0].
- RD_LAT, 2, cycles from grant cycle to data cycle (RAM latency incl. address register); must be ≥1.
- VGA_MAX, 4, max consecutive VGA grants while cpu_rreq is pending.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- test_rreq  in  1  test read request, held until granted
- test_raddr  in  32  test read address
- test_rgnt  out  1  test grant (combinational)
- test_rvalid  out  1  rdata belongs to test
- vga_rreq  in  1  VGA read request
- vga_raddr  in  32  VGA read address
- vga_rgnt  out  1  VGA grant
- vga_rvalid  out  1  rdata belongs to VGA
- cpu_rreq  in  1  CPU read request
- cpu_raddr  in  32  CPU read address
- cpu_rgnt  out  1  CPU grant
- cpu_rvalid  out  1  rdata belongs to CPU
- cpu_wren  in  1  CPU write strobe, always accepted
- cpu_waddr  in  32  CPU write address
- cpu_wdata  in  8  CPU write data
- mem_raddr  out  ADDR_W  registered RAM read address
- mem_waddr  out  ADDR_W  registered RAM write address
- mem_wdata  out  8  registered RAM write data
- mem_wren  out  1  registered RAM write enable
- mem_rdata  in  8  RAM read data
- rdata  out  8  read data to requesters, = mem_rdata (pass-through)

Behaviour:
- Reset (rst_n low, async): all *_rgnt forced 0; all *_rvalid 0; mem_raddr, mem_waddr, mem_wdata 0; mem_wren 0; vga_streak 0; tag pipeline cleared. In-flight reads at reset are discarded and never produce rvalid.
- Grant is combinational from current requests and state; at most one grant per cycle. A requester holds req and addr stable until it sees gnt high. A requester may re-request in the cycle after grant, giving back-to-back grants at 1 read/cycle.
- Winner selection:
  - test if test_rreq;
  - else CPU if cpu_rreq and (vga_streak == VGA_MAX or !vga_rreq);
  - else VGA if vga_rreq.
- Hazard hold-off: a candidate whose addr[ADDR_W-1:0] equals mem_waddr while mem_wren = 1 is ineligible that cycle. The next eligible requester in priority order wins; if none is eligible, no grant is issued.
- On the clock edge ending a grant cycle:
  - mem_raddr <= winner addr[ADDR_W-1:0];
  - tag {valid, id} is pushed into an RD_LAT-deep shift register.
- With no grant: mem_raddr holds its value; an invalid tag is pushed.
- rvalid: exactly one of *_rvalid is high, for one cycle, during cycle n+RD_LAT for a grant in cycle n. rdata is valid in that cycle. Returns are strictly in grant order.
- vga_streak:
  - +1 on each VGA grant while cpu_rreq = 1, saturating at VGA_MAX;
  - cleared on a CPU grant or whenever cpu_rreq = 0;
  - unchanged on test grants and idle cycles.
- Writes: each edge registers mem_wren <= cpu_wren, mem_waddr <= cpu_waddr[ADDR_W-1:0], mem_wdata <= cpu_wdata. The write lands one cycle after the strobe and is independent of read arbitration.
- Address bits above ADDR_W-1 are ignored (aliasing wraps).

Test Plan:
- Reset mid-read: grant CPU at addr 0x10, assert rst_n low at cycle n+1 -> cpu_rvalid never asserts; all outputs 0 during reset.
- Priority: test, VGA, CPU all request in the same cycle -> test_rgnt = 1 only. Next cycle (test dropped) -> vga_rgnt. rvalid sequence is test then VGA, RD_LAT = 2 cycles after each grant.
- Starvation: vga_rreq and cpu_rreq held high continuously, VGA_MAX = 4 -> grant pattern V,V,V,V,C,V,V,V,V,C…; cpu_rvalid appears 2 cycles after each C grant.
- Back-to-back: VGA streams addrs 0x100..0x107 every cycle with CPU idle -> 8 consecutive vga_rgnt pulses; vga_rvalid high for 8 consecutive cycles, rdata matching preloaded RAM bytes in order.
- Write hazard: cpu_wren at addr 0x55 with data 0xA5; next cycle cpu_rreq at 0x55 -> no CPU grant that cycle, CPU granted the following cycle; returned rdata = 0xA5.
- Alias: CPU reads 0x0008_0003 with ADDR_W = 19 -> mem_raddr = 0x00003.
